// File: rtl/user_id_readout_if.sv
// User ID readout bus.
// Carries the tie-cell word and control pulses into the readout block and the
// latched ID, status flags and serial stream back out.
//   master : drives mask_rev, relatch, ser_start; observes the outputs
//   slave  : the readout block itself
interface user_id_readout_if #(
  parameter int ID_WIDTH = 32
);
  logic [ID_WIDTH-1:0] mask_rev;
  logic                relatch;
  logic                ser_start;
  logic [ID_WIDTH-1:0] user_id;
  logic                id_valid;
  logic                id_changed;
  logic                ser_out;
  logic                ser_busy;
  logic                ser_done;

  modport master (
    output mask_rev, relatch, ser_start,
    input  user_id, id_valid, id_changed, ser_out, ser_busy, ser_done
  );

  modport slave (
    input  mask_rev, relatch, ser_start,
    output user_id, id_valid, id_changed, ser_out, ser_busy, ser_done
  );
endinterface

// File: rtl/user_id_readout.sv
// User ID readout.
// Debounces the mask_rev tie-cell word after reset, latches it into user_id,
// watches for later changes against the latched value, and serialises the
// latched word MSB-first on request.
// Ports:
//   wb_clk_i : system clock, all state on the rising edge
//   wb_rst_i : asynchronous active-high reset
//   bus      : user_id_readout_if.slave
//              in  mask_rev, relatch, ser_start
//              out user_id, id_valid, id_changed, ser_out, ser_busy, ser_done
module user_id_readout #(
  parameter int ID_WIDTH      = 32,
  parameter int SAMPLE_CYCLES = 4,
  parameter int CLK_DIV       = 2
) (
  input logic               wb_clk_i,
  input logic               wb_rst_i,
  user_id_readout_if.slave  bus
);

  localparam int CNT_W = $clog2(SAMPLE_CYCLES);
  localparam int IDX_W = $clog2(ID_WIDTH);
  localparam int DIV_W = $clog2(CLK_DIV) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(ID_WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic {
    SAMPLE = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] samp;
  logic                samp_vld;
  logic [CNT_W-1:0]    cnt;
  logic [ID_WIDTH-1:0] user_id_q;
  logic                id_valid_q;
  logic                id_changed_q;

  logic [ID_WIDTH-1:0] shreg;
  logic [IDX_W-1:0]    idx;
  logic [DIV_W-1:0]    div;
  logic                ser_out_q;
  logic                ser_busy_q;
  logic                ser_done_q;

  logic                take_relatch;
  logic                accept;
  logic                bit_end;

  // Relatch is honoured in LOCKED only while idle; it also beats a
  // simultaneous ser_start, so accept requires relatch low.
  assign take_relatch = (state == LOCKED) && bus.relatch && !ser_busy_q;
  assign accept       = id_valid_q && !ser_busy_q && bus.ser_start && !bus.relatch;
  assign bit_end      = ser_busy_q && (div == DIV_LAST);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state        <= SAMPLE;
      samp         <= '0;
      samp_vld     <= 1'b0;
      cnt          <= '0;
      user_id_q    <= '0;
      id_valid_q   <= 1'b0;
      id_changed_q <= 1'b0;
      idx          <= '0;
      div          <= '0;
      ser_out_q    <= 1'b0;
      ser_busy_q   <= 1'b0;
      ser_done_q   <= 1'b0;
    end else begin
      ser_done_q <= 1'b0;

      case (state)
        SAMPLE: begin
          samp     <= bus.mask_rev;
          samp_vld <= 1'b1;
          // samp_vld low means samp holds nothing trustworthy yet, so the
          // first sample after reset or relatch always starts a fresh run.
          if (bus.relatch || !samp_vld || (bus.mask_rev != samp)) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            user_id_q  <= bus.mask_rev;
            id_valid_q <= 1'b1;
            cnt        <= '0;
            state      <= LOCKED;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOCKED: begin
          if (take_relatch) begin
            id_valid_q   <= 1'b0;
            id_changed_q <= 1'b0;
            cnt          <= '0;
            samp_vld     <= 1'b0;
            state        <= SAMPLE;
          end else if (bus.mask_rev != user_id_q) begin
            id_changed_q <= 1'b1;
          end
        end
        default: state <= SAMPLE;
      endcase

      if (accept) begin
        ser_busy_q <= 1'b1;
        ser_out_q  <= user_id_q[ID_WIDTH-1];
        idx        <= IDX_TOP;
        div        <= '0;
      end else if (bit_end) begin
        div <= '0;
        if (idx == '0) begin
          ser_busy_q <= 1'b0;
          ser_out_q  <= 1'b0;
          ser_done_q <= 1'b1;
        end else begin
          idx       <= idx - 1'b1;
          ser_out_q <= shreg[ID_WIDTH-1];
        end
      end else if (ser_busy_q) begin
        div <= div + 1'b1;
      end
    end
  end

  // Snapshot of user_id for the shift; the MSB is already on ser_out, so the
  // register holds the remaining bits left-aligned.
  always_ff @(posedge wb_clk_i) begin
    if (accept) begin
      shreg <= {user_id_q[ID_WIDTH-2:0], 1'b0};
    end else if (bit_end) begin
      shreg <= {shreg[ID_WIDTH-2:0], 1'b0};
    end
  end

  assign bus.user_id    = user_id_q;
  assign bus.id_valid   = id_valid_q;
  assign bus.id_changed = id_changed_q;
  assign bus.ser_out    = ser_out_q;
  assign bus.ser_busy   = ser_busy_q;
  assign bus.ser_done   = ser_done_q;

endmodule
